// File: rtl/spi_pkg.sv
// Shared types and default constants for the SPI send controller.
package spi_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int CLK_DIV_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    DONE
  } state_e;

endpackage

// File: rtl/rise_detect.sv
// Single-flop rising-edge detector for an already-synchronised level input.
module rise_detect (
  input  logic clk_100,
  input  logic s_rst,
  input  logic din,
  output logic rise
);

  logic prev_q, prev_d;

  // The previous value tracks the input even in reset, so a level held high
  // across reset release is not mistaken for a fresh edge.
  always_comb prev_d = din;

  always_ff @(posedge clk_100) begin
    prev_q <= prev_d;
  end

  assign rise = din & ~prev_q & ~s_rst;

endmodule

// File: rtl/spi_send_ctrl.sv
// Button-driven counter that ships its value out as one SPI mode-0 frame (MSB first).
// Optional receive path: define SPI_SEND_CTRL_RX_EN to capture spi_miso into rx_data.
module spi_send_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic              clk_100,
  input  logic              s_rst,
  input  logic              next_count,
  input  logic              start_send,
  input  logic              spi_miso,
  output logic [DATA_W-1:0] count,
  output logic              spi_sclk,
  output logic              spi_mosi,
  output logic              spi_cs_n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam int BIT_W = $clog2(DATA_W) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  logic next_rise, start_rise;

  rise_detect u_next_rise (
    .clk_100 (clk_100),
    .s_rst   (s_rst),
    .din     (next_count),
    .rise    (next_rise)
  );

  rise_detect u_start_rise (
    .clk_100 (clk_100),
    .s_rst   (s_rst),
    .din     (start_send),
    .rise    (start_rise)
  );

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              phase_q, phase_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic              cs_n_q, cs_n_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              in_frame;
  logic              sclk_rise;

  // NOTE: every variable gets its default before the case, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    phase_d   = phase_q;
    tx_d      = tx_q;
    count_d   = next_rise ? count_q + DATA_W'(1) : count_q;
    sclk_rise = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_rise) begin
          tx_d    = count_q;
          div_d   = '0;
          state_d = CS_SETUP;
        end
      end
      CS_SETUP: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          bit_d   = '0;
          phase_d = 1'b0;
          state_d = SHIFT;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!phase_q) begin
            phase_d   = 1'b1;
            sclk_rise = 1'b1;
          end else begin
            // Falling sclk edge: the only point where mosi moves to the next bit.
            phase_d = 1'b0;
            tx_d    = tx_q << 1;
            if (bit_q == BIT_LAST) state_d = CS_HOLD;
            else                   bit_d   = bit_q + BIT_W'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      CS_HOLD: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = DONE;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Pin values are decoded from the next state so the pins themselves are flops.
    in_frame = (state_d == CS_SETUP) || (state_d == SHIFT) || (state_d == CS_HOLD);
    cs_n_d   = ~in_frame;
    busy_d   = in_frame;
    done_d   = (state_d == DONE);
    sclk_d   = (state_d == SHIFT) && phase_d;
    mosi_d   = ((state_d == CS_SETUP) || (state_d == SHIFT)) ? tx_d[DATA_W-1] : 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_100) begin
    if (s_rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
      tx_q    <= '0;
      count_q <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      tx_q    <= tx_d;
      count_q <= count_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign count    = count_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;
  assign spi_cs_n = cs_n_q;
  assign busy     = busy_q;
  assign done     = done_q;

`ifdef SPI_SEND_CTRL_RX_EN
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;

  always_comb begin
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    if (sclk_rise) rx_sh_d = {rx_sh_q[DATA_W-2:0], spi_miso};
    if (state_d == DONE) begin
      rx_data_d  = rx_sh_q;
      rx_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_100) begin
    if (s_rst) begin
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
`else
  logic unused_rx;
  assign unused_rx = spi_miso ^ sclk_rise;
  assign rx_data   = '0;
  assign rx_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_send_ctrl.sv
// Directed bench for spi_send_ctrl: expected frames go into a queue, a monitor checks each completed frame.
module tb_spi_send_ctrl;

  localparam int DATA_W    = 8;
  localparam int CLK_DIV   = 4;
  localparam int FRAME_CYC = CLK_DIV * (2 * DATA_W + 2);

  logic              clk_100 = 1'b0;
  logic              s_rst = 1'b1;
  logic              next_count = 1'b0;
  logic              start_send = 1'b0;
  logic              spi_miso;
  logic [DATA_W-1:0] count;
  logic              spi_sclk, spi_mosi, spi_cs_n;
  logic              busy, done;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;

  spi_send_ctrl #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV)) dut (
    .clk_100    (clk_100),
    .s_rst      (s_rst),
    .next_count (next_count),
    .start_send (start_send),
    .spi_miso   (spi_miso),
    .count      (count),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .spi_cs_n   (spi_cs_n),
    .busy       (busy),
    .done       (done),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid)
  );

  assign spi_miso = spi_mosi;

  always #5 clk_100 = ~clk_100;

  int n_pass   = 0;
  int n_total  = 0;
  int done_cnt = 0;
  logic [DATA_W-1:0] sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: collects mosi at each sclk rise, counts chip-select cycles, checks on done.
  initial begin
    int                cs_cyc = 0;
    int                n_bits = 0;
    logic [DATA_W-1:0] mosi_sh = '0;
    logic [DATA_W-1:0] exp_frame;
    logic              sclk_prev = 1'b0;
    forever begin
      @(negedge clk_100);
      if (s_rst) begin
        cs_cyc  = 0;
        n_bits  = 0;
        mosi_sh = '0;
      end else begin
        if (!spi_cs_n) cs_cyc++;
        if (spi_sclk && !sclk_prev) begin
          mosi_sh = {mosi_sh[DATA_W-2:0], spi_mosi};
          n_bits++;
        end
        if (done) begin
          done_cnt++;
          if (sb_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_done: got done pulse, expected no frame");
          end else begin
            exp_frame = sb_q.pop_front();
            check("frame_mosi", mosi_sh, exp_frame);
            check("frame_cs_len", cs_cyc, FRAME_CYC);
            check("frame_bits", n_bits, DATA_W);
            check("done_cs_n", spi_cs_n, 1);
            check("done_busy", busy, 0);
`ifdef SPI_SEND_CTRL_RX_EN
            check("rx_valid", rx_valid, 1);
            check("rx_data", rx_data, exp_frame);
`else
            check("rx_valid_tied", rx_valid, 0);
            check("rx_data_tied", rx_data, 0);
`endif
          end
          cs_cyc  = 0;
          n_bits  = 0;
          mosi_sh = '0;
        end
      end
      sclk_prev = spi_sclk;
    end
  end

  task automatic tick();
    @(posedge clk_100);
    #1;
  endtask

  task automatic pulse_next(input int n);
    for (int i = 0; i < n; i++) begin
      next_count = 1'b1;
      tick();
      next_count = 1'b0;
      tick();
    end
  endtask

  task automatic do_reset();
    s_rst = 1'b1;
    tick();
    tick();
    s_rst = 1'b0;
    tick();
  endtask

  task automatic start_frame(input logic [DATA_W-1:0] frame);
    start_send = 1'b1;
    tick();
    check("start_busy", busy, 1);
    check("start_cs_n", spi_cs_n, 0);
    check("start_sclk", spi_sclk, 0);
    check("start_mosi_msb", spi_mosi, frame[DATA_W-1]);
    start_send = 1'b0;
    tick();
  endtask

  task automatic wait_done(input string name);
    int start_cnt = done_cnt;
    for (int i = 0; i < FRAME_CYC + 20 && done_cnt == start_cnt; i++) tick();
    check(name, done_cnt, start_cnt + 1);
  endtask

  initial begin
    int d0;

    // Reset values, with next_count held high across reset release.
    s_rst      = 1'b1;
    next_count = 1'b1;
    tick();
    tick();
    check("rst_count", count, 0);
    check("rst_cs_n", spi_cs_n, 1);
    check("rst_sclk", spi_sclk, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    s_rst = 1'b0;
    tick();
    tick();
    check("held_high_no_edge", count, 0);
    next_count = 1'b0;
    tick();

    pulse_next(3);
    check("count_3", count, 3);

    do_reset();
    pulse_next(255);
    check("count_255", count, 8'hFF);
    pulse_next(1);
    check("count_wrap", count, 0);

    // 0xA5 frame, with a second start edge mid-frame that must be dropped.
    pulse_next(8'hA5);
    check("count_a5", count, 8'hA5);
    sb_q.push_back(8'hA5);
    start_frame(8'hA5);
    repeat (20) tick();
    start_send = 1'b1;
    tick();
    start_send = 1'b0;
    tick();
    wait_done("a5_done");
    d0 = done_cnt;
    repeat (FRAME_CYC + 10) tick();
    check("busy_start_ignored", done_cnt, d0);
    check("idle_after_ignore", busy, 0);

    // Counter bumped during a frame: frame keeps old value.
    sb_q.push_back(8'hA5);
    start_frame(8'hA5);
    repeat (8) tick();
    pulse_next(1);
    check("count_mid_frame", count, 8'hA6);
    wait_done("midcount_done");
    check("count_after_frame", count, 8'hA6);

    // Coincident edges in IDLE: frame carries the pre-increment value.
    do_reset();
    pulse_next(8'h0F);
    sb_q.push_back(8'h0F);
    next_count = 1'b1;
    start_send = 1'b1;
    tick();
    check("both_busy", busy, 1);
    next_count = 1'b0;
    start_send = 1'b0;
    tick();
    check("both_count", count, 8'h10);
    wait_done("both_done");

    // Reset during SHIFT bit 3 aborts with no done.
    start_frame(8'h10);
    repeat (28) tick();
    check("abort_in_shift", spi_cs_n, 0);
    s_rst = 1'b1;
    tick();
    check("abort_cs_n", spi_cs_n, 1);
    check("abort_sclk", spi_sclk, 0);
    check("abort_count", count, 0);
    check("abort_busy", busy, 0);
    s_rst = 1'b0;
    d0 = done_cnt;
    repeat (FRAME_CYC + 10) tick();
    check("abort_no_done", done_cnt, d0);

    // 0x3C frame; with the receive path built, loopback must return it.
    pulse_next(8'h3C);
    sb_q.push_back(8'h3C);
    start_frame(8'h3C);
    wait_done("3c_done");

    repeat (5) tick();
    check("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spi_send_ctrl.md
SPI_SEND_CTRL -- requirements
Module: spi_send_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, the width of the counter and of the SPI frame.
REQ-002 The block SHALL have parameter CLK_DIV, default 4, the number of clk_100 cycles per SCLK half-period; legal values are >= 1.
REQ-003 The block SHALL have port clk_100, input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port s_rst, input, 1 bit, reset, synchronous and active-high.
REQ-005 The block SHALL have port next_count, input, 1 bit, synchronised button level; its rising edge increments the counter.
REQ-006 The block SHALL have port start_send, input, 1 bit, synchronised button level; its rising edge starts a frame.
REQ-007 The block SHALL have port spi_miso, input, 1 bit, SPI slave data.
REQ-008 The block SHALL have port count, output, DATA_W bits, current counter value.
REQ-009 The block SHALL have ports spi_sclk, spi_mosi and spi_cs_n, each output, 1 bit, the SPI master pins (mode 0, MSB first).
REQ-010 The block SHALL have port busy, output, 1 bit, high while a frame is in progress.
REQ-011 The block SHALL have port done, output, 1 bit, one-cycle pulse at the end of a frame.
REQ-012 The block SHALL have ports rx_data, output, DATA_W bits, and rx_valid, output, 1 bit, the received frame and its one-cycle qualifier.

Function
REQ-013 Rising-edge detection SHALL use one previous-value register per input; an edge is current=1 and previous=0.
REQ-014 A next_count edge SHALL increment count by 1 in the following cycle, wrapping from 2^DATA_W-1 to 0, whether or not busy is high.
REQ-015 The FSM SHALL have states IDLE, CS_SETUP, SHIFT, CS_HOLD and DONE.
REQ-016 In IDLE, a start_send edge SHALL latch count into the tx shift register and enter CS_SETUP, setting spi_cs_n=0 and busy=1 in the next cycle.
REQ-017 When next_count and start_send edges coincide in IDLE, the latched frame SHALL be the pre-increment count.
REQ-018 A start_send edge while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-019 CS_SETUP SHALL last CLK_DIV cycles with spi_sclk=0 and spi_mosi=tx MSB.
REQ-020 SHIFT SHALL send DATA_W bits of 2*CLK_DIV cycles each: spi_sclk=0 for the first CLK_DIV cycles and 1 for the second CLK_DIV cycles.
REQ-021 In SHIFT, spi_mosi SHALL change only at the sclk 1->0 transition.
REQ-022 CS_HOLD SHALL last CLK_DIV cycles with spi_sclk=0 and spi_cs_n=0.
REQ-023 DONE SHALL last 1 cycle with spi_cs_n=1, busy=0 and done=1, then return to IDLE.
REQ-024 Frame length from the first spi_cs_n=0 cycle through the last spi_cs_n=0 cycle SHALL be CLK_DIV*(2*DATA_W+2) cycles (72 at the defaults).
REQ-025 The divider counter SHALL be $clog2(CLK_DIV)+1 bits and the bit counter SHALL be $clog2(DATA_W)+1 bits, with no truncation.
REQ-026 All SPI outputs SHALL be driven directly from flops.

Reset
REQ-027 On s_rst=1, the block SHALL set count=0, state=IDLE, spi_cs_n=1, spi_sclk=0, spi_mosi=0, busy=0, done=0, rx_data=0 and rx_valid=0 at the next clock edge.
REQ-028 During s_rst, the previous-value registers SHALL load the current input levels, so that an input held high across reset release does not produce an edge.
REQ-029 s_rst asserted mid-frame SHALL abort the frame without a done or rx_valid pulse.
REQ-030 s_rst SHALL take priority over every edge occurring in the same cycle.

Configuration
REQ-031 With macro SPI_SEND_CTRL_RX_EN defined, the block SHALL sample spi_miso on each sclk 0->1 transition into an rx shift register, MSB first.
REQ-032 With SPI_SEND_CTRL_RX_EN defined, rx_data SHALL update and rx_valid SHALL pulse in the same cycle as done.
REQ-033 Without SPI_SEND_CTRL_RX_EN, spi_miso SHALL be unused, no rx register SHALL exist, and rx_data and rx_valid SHALL be tied to 0.

Structure
REQ-034 Package spi_pkg SHALL hold the FSM state enum typedef and the default constants for DATA_W and CLK_DIV.
REQ-035 Sub-module rise_detect (one flop, with a reset-load input) SHALL be instantiated once for next_count and once for start_send.
REQ-036 The FSM, divider, shift registers and counter SHALL reside in spi_send_ctrl.

Verification
REQ-037 Bench SHALL apply 3 next_count edges after reset and require count=3; with DATA_W=8, it SHALL apply 256 edges and require count=0.
REQ-038 Bench SHALL set count=0xA5, apply a start_send edge and require: spi_cs_n low for 72 cycles, MOSI sampled at sclk rise = 1,0,1,0,0,1,0,1, then one done pulse.
REQ-039 Bench SHALL apply a start_send edge plus a next_count edge at frame cycle 10 and require the frame to carry the old value and count+1 after the frame.
REQ-040 Bench SHALL apply simultaneous edges in IDLE with count=0x0F and require frame=0x0F and count=0x10.
REQ-041 Bench SHALL assert s_rst at SHIFT bit 3 and require spi_cs_n=1, spi_sclk=0, count=0 the next cycle and no done pulse.
REQ-042 Bench SHALL, with SPI_SEND_CTRL_RX_EN defined and spi_miso looped to spi_mosi, send 0x3C and require rx_data=0x3C with rx_valid coincident with done.
